// File: rtl/apb_burst_master.sv
// -----------------------------------------------------------------------------
// apb_burst_master
//
// Turns a burst command (direction, start address, transfer size, beat count)
// into a sequence of APB transfers. Write beats arrive right-justified on a
// valid/ready stream and are lane-placed with matching byte strobes; read beats
// are extracted from their byte lanes, zero-extended and returned right-
// justified on a valid/ready stream. Each burst ends with a one-cycle done
// pulse, a status code and the number of beats completed without error.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      burst command handshake
//   cmd_wr                   1 = write burst, 0 = read burst
//   cmd_addr                 start byte address
//   cmd_size                 0 = full bus word, 1 = halfword, 2/3 = byte
//   cmd_len                  beat count (0 runs a single beat)
//   wdata_valid/ready, wdata right-justified write beat stream
//   rdata_valid/ready, rdata right-justified read beat stream
//   done                     one-cycle pulse when a burst finishes
//   status                   0 = OK, 1 = SLVERR, 2 = TIMEOUT (held until next done)
//   beats_done               error-free beats of the most recent burst
//   paddr, psel, penable,
//   pwrite, pwdata, pstrb    APB requester outputs
//   prdata, pready, pslverr  APB completer responses
//
// Build option
//   APB_TIMEOUT_EN  when defined, an ACCESS phase that sees no pready for
//                   TIMEOUT_CYCLES cycles is abandoned and the burst ends
//                   with status TIMEOUT. Without it ACCESS waits forever.
// -----------------------------------------------------------------------------
module apb_burst_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  // burst command
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [1:0]              cmd_size,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  // write beat stream
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  // read beat stream
  output logic                    rdata_valid,
  input  logic                    rdata_ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  // burst completion
  output logic                    done,
  output logic [1:0]              status,
  output logic [LEN_WIDTH-1:0]    beats_done,
  // APB requester
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int LANE_WIDTH  = $clog2(STRB_WIDTH);
  localparam int SHIFT_WIDTH = LANE_WIDTH + 3;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_SLVERR = 2'd1;
`ifdef APB_TIMEOUT_EN
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam int         TMO_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter holds the number of pready-less ACCESS cycles already seen,
  // so the cycle that would bring it to TIMEOUT_CYCLES is the one that sees
  // it at TIMEOUT_CYCLES-1.
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_RBEAT,
    S_DONE
  } state_t;

  // Reserved encoding 3 is folded into SZ_BYTE when the command is latched,
  // so the datapath only ever sees these three values.
  typedef enum logic [1:0] {
    SZ_FULL = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  state_t               state;
  size_t                size_q;
  logic [LEN_WIDTH-1:0] beats_left;
`ifdef APB_TIMEOUT_EN
  logic [TMO_WIDTH-1:0] tmo_cnt;
`endif

  // Lane placement derived from the live address and the burst size.
  logic [LANE_WIDTH-1:0]  lane;
  logic [LANE_WIDTH-1:0]  eff_lane;
  logic [SHIFT_WIDTH-1:0] lane_shift;
  logic [STRB_WIDTH-1:0]  beat_strb;
  logic [DATA_WIDTH-1:0]  beat_mask;
  logic [ADDR_WIDTH-1:0]  addr_step;
  logic [DATA_WIDTH-1:0]  placed_wdata;
  logic [DATA_WIDTH-1:0]  extracted_rdata;
  logic                   last_beat;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    lane      = paddr[LANE_WIDTH-1:0];
    eff_lane  = '0;
    beat_strb = '1;
    beat_mask = '1;
    addr_step = ADDR_WIDTH'(STRB_WIDTH);
    case (size_q)
      SZ_HALF: begin
        // Halfwords sit on an even lane pair regardless of paddr[0].
        eff_lane  = lane & ~LANE_WIDTH'(1);
        beat_strb = STRB_WIDTH'(2'b11) << eff_lane;
        beat_mask = DATA_WIDTH'(16'hFFFF);
        addr_step = ADDR_WIDTH'(2);
      end
      SZ_BYTE: begin
        eff_lane  = lane;
        beat_strb = STRB_WIDTH'(1) << lane;
        beat_mask = DATA_WIDTH'(8'hFF);
        addr_step = ADDR_WIDTH'(1);
      end
      default: ;
    endcase
    lane_shift      = {eff_lane, 3'b000};
    placed_wdata    = (wdata & beat_mask) << lane_shift;
    extracted_rdata = (prdata >> lane_shift) & beat_mask;
    last_beat       = (beats_left == LEN_WIDTH'(1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      size_q      <= SZ_FULL;
      beats_left  <= '0;
      cmd_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
      status      <= ST_OK;
      beats_done  <= '0;
      paddr       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      // done is a pulse: it is only raised on the edge that enters S_DONE.
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready  <= 1'b0;
            paddr      <= cmd_addr;
            pwrite     <= cmd_wr;
            beats_done <= '0;
            beats_left <= (cmd_len == '0) ? LEN_WIDTH'(1) : cmd_len;
            case (cmd_size)
              2'd0:    size_q <= SZ_FULL;
              2'd1:    size_q <= SZ_HALF;
              default: size_q <= SZ_BYTE;
            endcase
            if (cmd_wr) begin
              wdata_ready <= 1'b1;
              state       <= S_WDATA;
            end else begin
              pstrb <= '0;
              psel  <= 1'b1;
              state <= S_SETUP;
            end
          end
        end

        S_WDATA: begin
          if (wdata_valid) begin
            wdata_ready <= 1'b0;
            pwdata      <= placed_wdata;
            pstrb       <= beat_strb;
            psel        <= 1'b1;
            state       <= S_SETUP;
          end
        end

        S_SETUP: begin
          penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pslverr) begin
              // Abandon the rest of the burst; no more write beats are pulled.
              status <= ST_SLVERR;
              done   <= 1'b1;
              state  <= S_DONE;
            end else if (!pwrite) begin
              rdata       <= extracted_rdata;
              rdata_valid <= 1'b1;
              state       <= S_RBEAT;
            end else begin
              beats_done <= beats_done + LEN_WIDTH'(1);
              beats_left <= beats_left - LEN_WIDTH'(1);
              paddr      <= paddr + addr_step;
              if (last_beat) begin
                status <= ST_OK;
                done   <= 1'b1;
                state  <= S_DONE;
              end else begin
                wdata_ready <= 1'b1;
                state       <= S_WDATA;
              end
            end
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            status  <= ST_TIMEOUT;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
          end
`endif
        end

        S_RBEAT: begin
          if (rdata_ready) begin
            rdata_valid <= 1'b0;
            beats_done  <= beats_done + LEN_WIDTH'(1);
            beats_left  <= beats_left - LEN_WIDTH'(1);
            paddr       <= paddr + addr_step;
            if (last_beat) begin
              status <= ST_OK;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              psel  <= 1'b1;
              state <= S_SETUP;
            end
          end
        end

        S_DONE: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          psel      <= 1'b0;
          penable   <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
